// File: rtl/counter_core.sv
// Prescaled WIDTH-bit up/down timebase counter with a one-cycle period-wrap pulse.
// Optional sticky wrap flag (ovf_sticky/ovf_clr) enabled by defining COUNTER_OVF_STICKY_EN.
module counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             counter_en,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] prescale,
  input  logic             upnotdown,
  input  logic             soft_reset,
  output logic [WIDTH-1:0] counter_val,
  output logic             period_wrap
`ifdef COUNTER_OVF_STICKY_EN
  ,
  output logic             ovf_sticky,
  input  logic             ovf_clr
`endif
);

  logic [WIDTH-1:0] psc_cnt;
  logic [WIDTH-1:0] psc_next;
  logic [WIDTH-1:0] val_next;
  logic             wrap_next;
  logic             tick;

  // >= rather than == so a prescale lowered below psc_cnt ticks on the next cycle
  assign tick = counter_en & (psc_cnt >= prescale);

  always_comb begin
    psc_next  = psc_cnt;
    val_next  = counter_val;
    wrap_next = 1'b0;
    if (soft_reset) begin
      psc_next = '0;
      val_next = '0;
    end else if (tick) begin
      psc_next = '0;
      if (upnotdown) begin
        if (counter_val >= period) begin
          val_next  = '0;
          wrap_next = 1'b1;
        end else begin
          val_next = counter_val + WIDTH'(1);
        end
      end else begin
        if (counter_val == '0) begin
          val_next  = period;
          wrap_next = 1'b1;
        end else begin
          val_next = counter_val - WIDTH'(1);
        end
      end
    end else if (counter_en) begin
      psc_next = psc_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt     <= '0;
      counter_val <= '0;
      period_wrap <= 1'b0;
    end else begin
      psc_cnt     <= psc_next;
      counter_val <= val_next;
      period_wrap <= wrap_next;
    end
  end

`ifdef COUNTER_OVF_STICKY_EN
  // Set follows wrap_next so the flag rises together with period_wrap; set beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (wrap_next) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_counter_core.sv
// Self-checking bench for counter_core: scoreboard of expected (value, wrap) per clock,
// popped and compared 1 time unit after each rising edge.
module tb_counter_core;

  logic       clk;
  logic       rst;
  logic       counter_en;
  logic [7:0] period;
  logic [7:0] prescale;
  logic       upnotdown;
  logic       soft_reset;
  logic [7:0] counter_val;
  logic       period_wrap;
`ifdef COUNTER_OVF_STICKY_EN
  logic       ovf_sticky;
  logic       ovf_clr;
`endif

  typedef struct {
    logic [7:0] val;
    logic       wrap;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  counter_core #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .counter_en  (counter_en),
    .period      (period),
    .prescale    (prescale),
    .upnotdown   (upnotdown),
    .soft_reset  (soft_reset),
    .counter_val (counter_val),
    .period_wrap (period_wrap)
`ifdef COUNTER_OVF_STICKY_EN
    ,
    .ovf_sticky  (ovf_sticky),
    .ovf_clr     (ovf_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset pulse between negedges; the next rising edge is cycle 1 of a test
  task automatic apply_reset;
    @(negedge clk);
    rst        = 1'b1;
    soft_reset = 1'b0;
`ifdef COUNTER_OVF_STICKY_EN
    ovf_clr    = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    period = 8'd4; prescale = 8'd0; upnotdown = 1'b1; counter_en = 1'b1;
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.push_back('{val: 8'd0, wrap: 1'b0, tag: "reset_async"});
    exp_q.push_back('{val: 8'd0, wrap: 1'b0, tag: "reset_held"});
    #2;
    e = exp_q.pop_front();
    checks++;
    if (counter_val !== e.val) begin
      errors++; $display("[TB] FAIL %s val got %0d exp %0d", e.tag, counter_val, e.val);
    end
    checks++;
    if (period_wrap !== e.wrap) begin
      errors++; $display("[TB] FAIL %s wrap got %0b exp %0b", e.tag, period_wrap, e.wrap);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (counter_val !== e.val) begin
      errors++; $display("[TB] FAIL %s val got %0d exp %0d", e.tag, counter_val, e.val);
    end
    checks++;
    if (period_wrap !== e.wrap) begin
      errors++; $display("[TB] FAIL %s wrap got %0b exp %0b", e.tag, period_wrap, e.wrap);
    end
`ifdef COUNTER_OVF_STICKY_EN
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_sticky got %0b exp 0", ovf_sticky);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // period=4, prescale=0, up: 1,2,3,4,0,... with wrap whenever the value returns to 0
  task automatic test_up_basic;
    exp_t e;
    period = 8'd4; prescale = 8'd0; upnotdown = 1'b1; counter_en = 1'b1;
    apply_reset();
    for (int k = 1; k <= 12; k++)
      exp_q.push_back('{val: 8'(k % 5), wrap: (k % 5 == 0), tag: $sformatf("up_basic[%0d]", k)});
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (counter_val !== e.val) begin
        errors++; $display("[TB] FAIL %s val got %0d exp %0d", e.tag, counter_val, e.val);
      end
      checks++;
      if (period_wrap !== e.wrap) begin
        errors++; $display("[TB] FAIL %s wrap got %0b exp %0b", e.tag, period_wrap, e.wrap);
      end
    end
  endtask

  // prescale=2: each value held 3 clocks, first wrap on clock 15
  task automatic test_prescale;
    exp_t e;
    period = 8'd4; prescale = 8'd2; upnotdown = 1'b1; counter_en = 1'b1;
    apply_reset();
    for (int k = 1; k <= 18; k++)
      exp_q.push_back('{val: 8'((k / 3) % 5), wrap: (k % 3 == 0) && ((k / 3) % 5 == 0),
                        tag: $sformatf("prescale[%0d]", k)});
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (counter_val !== e.val) begin
        errors++; $display("[TB] FAIL %s val got %0d exp %0d", e.tag, counter_val, e.val);
      end
      checks++;
      if (period_wrap !== e.wrap) begin
        errors++; $display("[TB] FAIL %s wrap got %0b exp %0b", e.tag, period_wrap, e.wrap);
      end
    end
  endtask

  // Down from reset: reload to 3 immediately, then 2,1,0,3,...
  task automatic test_down;
    exp_t e;
    period = 8'd3; prescale = 8'd0; upnotdown = 1'b0; counter_en = 1'b1;
    apply_reset();
    for (int k = 1; k <= 9; k++)
      exp_q.push_back('{val: 8'(3 - ((k - 1) % 4)), wrap: ((k - 1) % 4 == 0),
                        tag: $sformatf("down[%0d]", k)});
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (counter_val !== e.val) begin
        errors++; $display("[TB] FAIL %s val got %0d exp %0d", e.tag, counter_val, e.val);
      end
      checks++;
      if (period_wrap !== e.wrap) begin
        errors++; $display("[TB] FAIL %s wrap got %0b exp %0b", e.tag, period_wrap, e.wrap);
      end
    end
  endtask

  // soft_reset at val=3, hold with en=0, resume; then soft_reset in down mode reloads on next tick
  task automatic test_soft_reset;
    exp_t e;
    int t_sr[13]   = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int t_en[13]   = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    int t_up[13]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int t_val[13]  = '{1, 2, 3, 0, 0, 0, 0, 0, 0, 1, 0, 4, 3};
    int t_wrap[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    period = 8'd4; prescale = 8'd0; upnotdown = 1'b1; counter_en = 1'b1;
    apply_reset();
    for (int k = 0; k < 13; k++) begin
      soft_reset = t_sr[k][0]; counter_en = t_en[k][0]; upnotdown = t_up[k][0];
      exp_q.push_back('{val: 8'(t_val[k]), wrap: t_wrap[k][0], tag: $sformatf("soft_reset[%0d]", k)});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (counter_val !== e.val) begin
        errors++; $display("[TB] FAIL %s val got %0d exp %0d", e.tag, counter_val, e.val);
      end
      checks++;
      if (period_wrap !== e.wrap) begin
        errors++; $display("[TB] FAIL %s wrap got %0b exp %0b", e.tag, period_wrap, e.wrap);
      end
    end
    soft_reset = 1'b0;
  endtask

  // psc_cnt survives en=0; lowering prescale below psc_cnt ticks on the next clock
  task automatic test_hold_prescale;
    exp_t e;
    int t_en[13]   = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int t_psc[13]  = '{2, 2, 2, 2, 2, 2, 2, 5, 5, 5, 1, 1, 1};
    int t_val[13]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3};
    period = 8'd9; prescale = 8'd2; upnotdown = 1'b1; counter_en = 1'b1;
    apply_reset();
    for (int k = 0; k < 13; k++) begin
      counter_en = t_en[k][0]; prescale = 8'(t_psc[k]);
      exp_q.push_back('{val: 8'(t_val[k]), wrap: 1'b0, tag: $sformatf("hold_psc[%0d]", k)});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (counter_val !== e.val) begin
        errors++; $display("[TB] FAIL %s val got %0d exp %0d", e.tag, counter_val, e.val);
      end
      checks++;
      if (period_wrap !== e.wrap) begin
        errors++; $display("[TB] FAIL %s wrap got %0b exp %0b", e.tag, period_wrap, e.wrap);
      end
    end
  endtask

  // Direction flip mid-count and period lowered below the current value, in both directions
  task automatic test_mode_change;
    exp_t e;
    int t_up[16]   = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    int t_per[16]  = '{9, 9, 9, 9, 9, 3, 3, 3, 3, 3, 3, 3, 3, 3, 1, 0};
    int t_val[16]  = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 3, 2, 3, 0, 1, 0};
    int t_wrap[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
    period = 8'd9; prescale = 8'd0; upnotdown = 1'b1; counter_en = 1'b1;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      upnotdown = t_up[k][0]; period = 8'(t_per[k]);
      exp_q.push_back('{val: 8'(t_val[k]), wrap: t_wrap[k][0], tag: $sformatf("mode[%0d]", k)});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (counter_val !== e.val) begin
        errors++; $display("[TB] FAIL %s val got %0d exp %0d", e.tag, counter_val, e.val);
      end
      checks++;
      if (period_wrap !== e.wrap) begin
        errors++; $display("[TB] FAIL %s wrap got %0b exp %0b", e.tag, period_wrap, e.wrap);
      end
    end
  endtask

  // period=0, prescale=1: value pinned at 0, wrap on every second clock
  task automatic test_period_zero;
    exp_t e;
    period = 8'd0; prescale = 8'd1; upnotdown = 1'b1; counter_en = 1'b1;
    apply_reset();
    for (int k = 1; k <= 8; k++)
      exp_q.push_back('{val: 8'd0, wrap: (k % 2 == 0), tag: $sformatf("period_zero[%0d]", k)});
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (counter_val !== e.val) begin
        errors++; $display("[TB] FAIL %s val got %0d exp %0d", e.tag, counter_val, e.val);
      end
      checks++;
      if (period_wrap !== e.wrap) begin
        errors++; $display("[TB] FAIL %s wrap got %0b exp %0b", e.tag, period_wrap, e.wrap);
      end
    end
  endtask

`ifdef COUNTER_OVF_STICKY_EN
  // Sticky rises with period_wrap, persists, survives a coinciding clear, drops on a lone clear
  task automatic test_ovf_sticky;
    exp_t e;
    int t_clr[6]  = '{0, 0, 0, 1, 1, 0};
    int t_val[6]  = '{1, 0, 1, 0, 1, 0};
    int t_wrap[6] = '{0, 1, 0, 1, 0, 1};
    int t_stk[6]  = '{0, 1, 1, 1, 0, 1};
    period = 8'd1; prescale = 8'd0; upnotdown = 1'b1; counter_en = 1'b1;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      ovf_clr = t_clr[k][0];
      exp_q.push_back('{val: 8'(t_val[k]), wrap: t_wrap[k][0], tag: $sformatf("sticky[%0d]", k)});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (counter_val !== e.val) begin
        errors++; $display("[TB] FAIL %s val got %0d exp %0d", e.tag, counter_val, e.val);
      end
      checks++;
      if (period_wrap !== e.wrap) begin
        errors++; $display("[TB] FAIL %s wrap got %0b exp %0b", e.tag, period_wrap, e.wrap);
      end
      checks++;
      if (ovf_sticky !== t_stk[k][0]) begin
        errors++; $display("[TB] FAIL %s ovf_sticky got %0b exp %0b", e.tag, ovf_sticky, t_stk[k][0]);
      end
    end
    ovf_clr = 1'b0;
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    counter_en = 1'b0;
    period     = 8'd0;
    prescale   = 8'd0;
    upnotdown  = 1'b1;
    soft_reset = 1'b0;
`ifdef COUNTER_OVF_STICKY_EN
    ovf_clr    = 1'b0;
`endif
    test_reset();
    test_up_basic();
    test_prescale();
    test_down();
    test_soft_reset();
    test_hold_prescale();
    test_mode_change();
    test_period_zero();
`ifdef COUNTER_OVF_STICKY_EN
    test_ovf_sticky();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
